// File: rtl/decim_enable_ctrl.sv
// Sequencing controller for the 2:1 decimation stage.
// Produces the input-rate enable (in_en) and the down-sampler clock enable (ds_en),
// flushes the upstream pipeline after each start, applies decimation-phase changes
// only on frame boundaries, and flags ds_en one clock later as y_valid.
module decim_enable_ctrl #(
    parameter int CLK_DIV   = 4,
    parameter int DECIM     = 2,
    parameter int PH_W      = 1,
    parameter int FLUSH_LEN = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    input  logic [PH_W-1:0] phase_sel,
    input  logic            phase_ld,
    output logic            in_en,
    output logic            ds_en,
    output logic            y_valid,
    output logic [PH_W-1:0] phase_cur,
    output logic            phase_err,
    output logic            busy,
    output logic [15:0]     sample_cnt
);

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int DCNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int FL_W   = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FLUSH,
        S_RUN,
        S_STOP
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [FL_W-1:0]    fcnt_q, fcnt_d;
    logic [DCNT_W-1:0]  dcnt_q, dcnt_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [PH_W-1:0]    phase_cur_q, phase_cur_d;
    logic [PH_W-1:0]    pend_q, pend_d;
    logic               pend_flag_q, pend_flag_d;
    logic               phase_err_q, phase_err_d;
    logic               y_valid_q;

    // Decodes taken from registered state only, so in_en/ds_en are glitch-free
    // and independent of the run/phase inputs in the same cycle.
    logic div_last;
    logic dcnt_last;
    logic framing;
    logic phase_hit;
    logic wrap;
    logic ld_ok;

    assign busy      = (state_q != S_IDLE);
    assign div_last  = (32'(div_q) == CLK_DIV - 1);
    assign in_en     = busy && div_last;
    assign framing   = (state_q == S_RUN) || (state_q == S_STOP);
    assign dcnt_last = (32'(dcnt_q) == DECIM - 1);
    assign phase_hit = (32'(dcnt_q) == 32'(phase_cur_q));
    assign ds_en     = in_en && framing && phase_hit;
    // A frame ends on the input sample that takes dcnt from DECIM-1 back to 0.
    assign wrap      = in_en && framing && dcnt_last;
    assign ld_ok     = phase_ld && (32'(phase_sel) < DECIM);

    assign y_valid    = y_valid_q;
    assign phase_cur  = phase_cur_q;
    assign phase_err  = phase_err_q;
    assign sample_cnt = cnt_q;

    // Next-state logic for the sequencer and its sample/frame counters.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        fcnt_d  = fcnt_q;
        dcnt_d  = dcnt_q;
        cnt_d   = cnt_q;

        if (ds_en) begin
            cnt_d = cnt_q + 16'd1;
        end

        if (busy) begin
            div_d = div_last ? '0 : div_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                div_d = '0;
                if (run) begin
                    fcnt_d  = '0;
                    dcnt_d  = '0;
                    cnt_d   = '0;
                    state_d = (FLUSH_LEN == 0) ? S_RUN : S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (!run) begin
                    // Nothing has reached the down-sampler yet, so abort at once.
                    state_d = S_IDLE;
                    div_d   = '0;
                end else if (in_en) begin
                    if (32'(fcnt_q) == FLUSH_LEN - 1) begin
                        state_d = S_RUN;
                        dcnt_d  = '0;
                    end else begin
                        fcnt_d = fcnt_q + 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (in_en) begin
                    dcnt_d = dcnt_last ? '0 : dcnt_q + 1'b1;
                end
                if (!run) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                // Finish the current frame; run is deliberately ignored here.
                if (in_en) begin
                    dcnt_d = dcnt_last ? '0 : dcnt_q + 1'b1;
                end
                if (wrap) begin
                    state_d = S_IDLE;
                    div_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                div_d   = '0;
            end
        endcase
    end

    // Next-state logic for the phase request path.
    always_comb begin
        phase_cur_d = phase_cur_q;
        pend_d      = pend_q;
        pend_flag_d = pend_flag_q;
        phase_err_d = phase_ld && !ld_ok;

        // A pending phase lands on a frame boundary, or at once while idle.
        if (((state_q == S_IDLE) || wrap) && pend_flag_q) begin
            phase_cur_d = pend_q;
            pend_flag_d = 1'b0;
        end

        // A fresh request always goes to the pending slot unless idle with
        // nothing queued, in which case it can take effect directly. When a
        // transfer happens in the same cycle the old value is the one applied.
        if (ld_ok) begin
            if ((state_q == S_IDLE) && !pend_flag_q) begin
                phase_cur_d = phase_sel;
            end else begin
                pend_d      = phase_sel;
                pend_flag_d = 1'b1;
            end
        end
    end

    // State registers; asynchronous reset returns everything to idle immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            fcnt_q      <= '0;
            dcnt_q      <= '0;
            cnt_q       <= '0;
            phase_cur_q <= '0;
            pend_q      <= '0;
            pend_flag_q <= 1'b0;
            phase_err_q <= 1'b0;
            y_valid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            fcnt_q      <= fcnt_d;
            dcnt_q      <= dcnt_d;
            cnt_q       <= cnt_d;
            phase_cur_q <= phase_cur_d;
            pend_q      <= pend_d;
            pend_flag_q <= pend_flag_d;
            phase_err_q <= phase_err_d;
            // Down-sampler output appears one clock after its enable.
            y_valid_q   <= ds_en;
        end
    end

endmodule

// File: tb/tb_decim_enable_ctrl.sv
// Bench for decim_enable_ctrl: directed run/stop/phase/reset sequence, an
// arithmetic reference model compared every cycle, and hand-computed checkpoints.
module tb_decim_enable_ctrl;

    localparam int CLK_DIV   = 4;
    localparam int DECIM     = 2;
    localparam int PH_W      = 2;
    localparam int FLUSH_LEN = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            run;
    logic [PH_W-1:0] phase_sel;
    logic            phase_ld;
    logic            in_en;
    logic            ds_en;
    logic            y_valid;
    logic [PH_W-1:0] phase_cur;
    logic            phase_err;
    logic            busy;
    logic [15:0]     sample_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int E, E2, E3, E4, E5;

    decim_enable_ctrl #(
        .CLK_DIV  (CLK_DIV),
        .DECIM    (DECIM),
        .PH_W     (PH_W),
        .FLUSH_LEN(FLUSH_LEN)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .phase_sel (phase_sel),
        .phase_ld  (phase_ld),
        .in_en     (in_en),
        .ds_en     (ds_en),
        .y_valid   (y_valid),
        .phase_cur (phase_cur),
        .phase_err (phase_err),
        .busy      (busy),
        .sample_cnt(sample_cnt)
    );

    always #5 clk = ~clk;

    // Edge index: after rising edge n, cyc == n.
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: mode 0 idle, 1 flush, 2 run, 3 stop. Timing is derived
    // from absolute counts (busy cycles, input samples) reduced modulo the rates.
    int   m_mode  = 0;
    int   m_bcyc  = 0;
    int   m_fl    = 0;
    int   m_rs    = 0;
    int   m_cnt   = 0;
    int   m_phase = 0;
    int   m_pend  = 0;
    logic m_pv    = 1'b0;
    logic m_err   = 1'b0;
    logic m_yv    = 1'b0;
    logic m_busy, m_in_en, m_active, m_ds_en, m_wrap, m_ldok;

    always_comb begin
        m_busy   = (m_mode != 0);
        m_in_en  = m_busy && ((m_bcyc % CLK_DIV) == CLK_DIV - 1);
        m_active = (m_mode == 2) || (m_mode == 3);
        m_ds_en  = m_in_en && m_active && ((m_rs % DECIM) == m_phase);
        m_wrap   = m_in_en && m_active && ((m_rs % DECIM) == DECIM - 1);
        m_ldok   = phase_ld && (int'(phase_sel) < DECIM);
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode <= 0; m_bcyc <= 0; m_fl <= 0; m_rs <= 0; m_cnt <= 0;
            m_phase <= 0; m_pend <= 0; m_pv <= 1'b0; m_err <= 1'b0; m_yv <= 1'b0;
        end else begin
            m_err <= phase_ld && (int'(phase_sel) >= DECIM);
            m_yv  <= m_ds_en;
            m_cnt <= (m_cnt + (m_ds_en ? 1 : 0)) % 65536;
            case (m_mode)
                0: begin
                    m_bcyc <= 0;
                    if (run) begin
                        m_fl <= 0; m_rs <= 0; m_cnt <= 0;
                        m_mode <= (FLUSH_LEN == 0) ? 2 : 1;
                    end
                end
                1: begin
                    if (!run) begin
                        m_mode <= 0; m_bcyc <= 0;
                    end else begin
                        m_bcyc <= m_bcyc + 1;
                        if (m_in_en) begin
                            m_fl <= m_fl + 1;
                            if (m_fl + 1 == FLUSH_LEN) begin
                                m_mode <= 2; m_rs <= 0;
                            end
                        end
                    end
                end
                2: begin
                    m_bcyc <= m_bcyc + 1;
                    if (m_in_en) m_rs <= m_rs + 1;
                    if (!run) m_mode <= 3;
                end
                default: begin
                    m_bcyc <= m_bcyc + 1;
                    if (m_in_en) m_rs <= m_rs + 1;
                    if (m_wrap) begin
                        m_mode <= 0; m_bcyc <= 0;
                    end
                end
            endcase
            if (((m_mode == 0) || m_wrap) && m_pv) begin
                m_phase <= m_pend; m_pv <= 1'b0;
            end
            if (m_ldok) begin
                if ((m_mode == 0) && !m_pv) begin
                    m_phase <= int'(phase_sel);
                end else begin
                    m_pend <= int'(phase_sel); m_pv <= 1'b1;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Every cycle: DUT outputs against the model.
    always @(negedge clk) begin
        chk("m_in_en",      32'(in_en),      32'(m_in_en));
        chk("m_ds_en",      32'(ds_en),      32'(m_ds_en));
        chk("m_y_valid",    32'(y_valid),    32'(m_yv));
        chk("m_busy",       32'(busy),       32'(m_busy));
        chk("m_phase_cur",  32'(phase_cur),  m_phase);
        chk("m_phase_err",  32'(phase_err),  32'(m_err));
        chk("m_sample_cnt", 32'(sample_cnt), m_cnt);
    end

    // Move to 2 time units after rising edge n (inputs driven here).
    task automatic go(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Move to the falling edge inside cycle n.
    task automatic at_cyc(input int n);
        @(negedge clk);
        while (cyc < n) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; phase_ld = 1'b0; phase_sel = '0;
        go(3);
        reset = 1'b0;
        at_cyc(4);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_in_en", 32'(in_en), 0);
        chk("rst_ds_en", 32'(ds_en), 0);
        chk("rst_y_valid", 32'(y_valid), 0);
        chk("rst_phase_cur", 32'(phase_cur), 0);
        chk("rst_sample_cnt", 32'(sample_cnt), 0);

        // Start with phase 0: 8 flush samples, then ds_en every other sample.
        go(6); run = 1'b1; E = cyc + 1;
        at_cyc(E + 3);  chk("t1_first_in_en", 32'(in_en), 1); chk("t1_flush_ds0", 32'(ds_en), 0);
        at_cyc(E + 31); chk("t1_last_flush_in_en", 32'(in_en), 1); chk("t1_flush_ds1", 32'(ds_en), 0);
        at_cyc(E + 35); chk("t1_ds_e35", 32'(ds_en), 1); chk("t1_cnt_e35", 32'(sample_cnt), 0);
        at_cyc(E + 36); chk("t1_yv_e36", 32'(y_valid), 1); chk("t1_cnt_e36", 32'(sample_cnt), 1);
        at_cyc(E + 39); chk("t1_in_en_e39", 32'(in_en), 1); chk("t1_ds_e39", 32'(ds_en), 0);
        at_cyc(E + 43); chk("t1_ds_e43", 32'(ds_en), 1);
        at_cyc(E + 44); chk("t1_cnt_e44", 32'(sample_cnt), 2);

        // Phase change requested mid-frame lands on the next wrap.
        go(E + 45); phase_sel = 2'd1; phase_ld = 1'b1;
        go(E + 46); phase_ld = 1'b0;
        at_cyc(E + 46); chk("t3_pc_pending", 32'(phase_cur), 0);
        at_cyc(E + 47); chk("t3_ds_wrap", 32'(ds_en), 0); chk("t3_pc_wrap", 32'(phase_cur), 0);
        at_cyc(E + 48); chk("t3_pc_applied", 32'(phase_cur), 1);
        at_cyc(E + 51); chk("t3_in_en_e51", 32'(in_en), 1); chk("t3_ds_e51", 32'(ds_en), 0);
        at_cyc(E + 55); chk("t3_ds_e55", 32'(ds_en), 1);

        // Out-of-range phase request.
        go(E + 56); phase_sel = 2'd3; phase_ld = 1'b1;
        go(E + 57); phase_ld = 1'b0; phase_sel = 2'd0;
        at_cyc(E + 57); chk("t4_err_pulse", 32'(phase_err), 1); chk("t4_pc_kept", 32'(phase_cur), 1);
        at_cyc(E + 58); chk("t4_err_clear", 32'(phase_err), 0); chk("t4_pc_kept2", 32'(phase_cur), 1);

        // Stop: frame completes, run glitch during STOP ignored.
        go(E + 60); run = 1'b0;
        go(E + 61); run = 1'b1;
        go(E + 62); run = 1'b0;
        at_cyc(E + 62); chk("t5_busy_stop", 32'(busy), 1);
        at_cyc(E + 63); chk("t5_in_en_wrap", 32'(in_en), 1); chk("t5_ds_wrap", 32'(ds_en), 1);
        chk("t5_cnt_e63", 32'(sample_cnt), 3);
        at_cyc(E + 64); chk("t5_idle_busy", 32'(busy), 0); chk("t5_idle_in_en", 32'(in_en), 0);
        chk("t5_cnt_e64", 32'(sample_cnt), 4);
        at_cyc(E + 67); chk("t5_no_in_en", 32'(in_en), 0);

        // Phase loads in IDLE take effect at once.
        go(E + 70); phase_sel = 2'd0; phase_ld = 1'b1;
        go(E + 71); phase_ld = 1'b0;
        at_cyc(E + 71); chk("t2_idle_pc0", 32'(phase_cur), 0);
        go(E + 73); phase_sel = 2'd1; phase_ld = 1'b1;
        go(E + 74); phase_ld = 1'b0;
        at_cyc(E + 74); chk("t2_idle_pc1", 32'(phase_cur), 1);
        go(E + 76); run = 1'b1; E2 = cyc + 1;
        at_cyc(E2 + 35); chk("t2_in_en_e35", 32'(in_en), 1); chk("t2_ds_e35", 32'(ds_en), 0);
        chk("t2_cnt_clr", 32'(sample_cnt), 0);
        at_cyc(E2 + 39); chk("t2_ds_e39", 32'(ds_en), 1);
        at_cyc(E2 + 43); chk("t2_ds_e43", 32'(ds_en), 0);
        at_cyc(E2 + 47); chk("t2_ds_e47", 32'(ds_en), 1); chk("t2_cnt_e47", 32'(sample_cnt), 1);

        // Stop again, then abort a flush.
        go(E2 + 50); run = 1'b0;
        go(E2 + 60); run = 1'b1; E3 = cyc + 1;
        go(E3 + 5); run = 1'b0;
        at_cyc(E3 + 6); chk("flush_abort_busy", 32'(busy), 0);

        // Reset mid-flush, restart from scratch with run still high.
        go(E3 + 10); run = 1'b1; E4 = cyc + 1;
        at_cyc(E4 + 19); chk("t6_busy_pre", 32'(busy), 1);
        go(E4 + 20); reset = 1'b1;
        at_cyc(E4 + 20);
        chk("t6_busy", 32'(busy), 0); chk("t6_in_en", 32'(in_en), 0);
        chk("t6_ds_en", 32'(ds_en), 0); chk("t6_pc", 32'(phase_cur), 0);
        chk("t6_cnt", 32'(sample_cnt), 0);
        go(E4 + 23); reset = 1'b0; E5 = cyc + 1;
        at_cyc(E5 + 31); chk("t6_in_en_flush", 32'(in_en), 1); chk("t6_ds_flush", 32'(ds_en), 0);
        at_cyc(E5 + 35); chk("t6_first_ds", 32'(ds_en), 1); chk("t6_cnt_e35", 32'(sample_cnt), 0);
        at_cyc(E5 + 36); chk("t6_yv", 32'(y_valid), 1); chk("t6_cnt_e36", 32'(sample_cnt), 1);
        go(E5 + 40); run = 1'b0;
        go(E5 + 60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
